// File: rtl/branch_update_queue.sv
// FIFO of resolved branch outcomes that drains one entry per cycle into the BHT update port.
// Optional feature: define BUQ_STATS_EN to build the branch and misprediction counters.
module branch_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [31:0]              res_pc,
    input  logic                     res_taken,
    input  logic                     res_pred_taken,
    input  logic                     update_hold,
    output logic                     update_en,
    output logic [31:0]              update_pc,
    output logic                     update_actual_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispredicts
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_pc [DEPTH];
    logic          mem_taken [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          upd_en_q, upd_en_d;
    logic [31:0]   upd_pc_q, upd_pc_d;
    logic          upd_tk_q, upd_tk_d;
    logic          acc, pop;

    // A full queue still accepts when the head leaves in the same cycle.
    assign pop       = (count_q != '0) & ~update_hold;
    assign res_ready = (count_q != CW'(DEPTH)) | pop;
    assign acc       = res_valid & res_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        upd_en_d = pop;
        upd_pc_d = upd_pc_q;
        upd_tk_d = upd_tk_q;
        count_d  = count_q + {{PW{1'b0}}, acc} - {{PW{1'b0}}, pop};
        if (acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            upd_pc_d = mem_pc[rd_ptr_q];
            upd_tk_d = mem_taken[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            upd_en_q <= 1'b0;
            upd_pc_q <= '0;
            upd_tk_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            upd_en_q <= upd_en_d;
            upd_pc_q <= upd_pc_d;
            upd_tk_q <= upd_tk_d;
        end
    end

    // Entry storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_pc[wr_ptr_q]    <= res_pc;
            mem_taken[wr_ptr_q] <= res_taken;
        end
    end

    assign update_en           = upd_en_q;
    assign update_pc           = upd_pc_q;
    assign update_actual_taken = upd_tk_q;
    assign count               = count_q;

`ifdef BUQ_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (acc && stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
        if (acc && (res_taken != res_pred_taken) && stat_mp_q != 32'hFFFF_FFFF)
            stat_mp_d = stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    logic stats_unused;
    assign stats_unused     = res_pred_taken;
    assign stat_branches    = 32'h0;
    assign stat_mispredicts = 32'h0;
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench: a queue-level model predicts each cycle's BHT write; a monitor checks the DUT.
module tb_branch_update_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic        res_pred_taken = 1'b0;
    logic        update_hold = 1'b0;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_actual_taken;
    logic [$clog2(DEPTH):0] count;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_update_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_taken(res_taken), .res_pred_taken(res_pred_taken),
        .update_hold(update_hold), .update_en(update_en),
        .update_pc(update_pc), .update_actual_taken(update_actual_taken),
        .count(count), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic tk; } ent_t;
    typedef struct { logic en; logic [31:0] pc; logic tk; } exp_t;

    ent_t mq[$];     // model queue contents
    exp_t expq[$];   // expected BHT write per edge
    longint m_br = 0, m_mp = 0;
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per edge, compared just after that edge.
    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("update_en", {31'b0, update_en}, {31'b0, e.en});
            if (e.en && update_en) begin
                chk("update_pc", update_pc, e.pc);
                chk("update_taken", {31'b0, update_actual_taken}, {31'b0, e.tk});
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic tk,
                        input logic pd, input logic hd, input logic rst = 1'b1);
        exp_t e;
        logic m_pop, m_rdy;
        @(negedge clk);
        res_valid = v; res_pc = pc; res_taken = tk; res_pred_taken = pd;
        update_hold = hd; rst_n = rst;
        #1;
        e.en = 1'b0; e.pc = '0; e.tk = 1'b0;
        if (rst) begin
            m_pop = (mq.size() != 0) && !hd;
            m_rdy = (mq.size() != DEPTH) || m_pop;
            chk("res_ready", {31'b0, res_ready}, {31'b0, m_rdy});
            chk("count", 32'(count), 32'(mq.size()));
            chk("stat_branches", stat_branches, 32'(m_br));
            chk("stat_mispredicts", stat_mispredicts, 32'(m_mp));
            if (m_pop) begin
                ent_t h;
                h = mq.pop_front();
                e.en = 1'b1; e.pc = h.pc; e.tk = h.tk;
            end
            if (v && m_rdy) begin
                ent_t n;
                n.pc = pc; n.tk = tk;
                mq.push_back(n);
`ifdef BUQ_STATS_EN
                if (m_br < 64'hFFFF_FFFF) m_br++;
                if (tk != pd && m_mp < 64'hFFFF_FFFF) m_mp++;
`endif
            end
        end else begin
            mq.delete();
            m_br = 0; m_mp = 0;
        end
        expq.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        step(1'b0, 0, 0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b0);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", {31'b0, res_ready}, 32'd1);
        chk("rst_update_pc", update_pc, 32'd0);
        chk("rst_stats", stat_branches | stat_mispredicts, 32'd0);

        // Single branch, two-edge latency
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Fill under hold, stalled fifth push, then release
        for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(4 * i), i[0], 1'b0, 1'b1);
        step(1'b1, 32'h20, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h20, 1'b1, 1'b1, 1'b0);
        idle(7);

        // Full plus simultaneous accept
        for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1);
        idle(6);

        // Wrap-around, back-to-back
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 32'h1000 + 32'(4 * i), i[1], i[0], 1'b0);
        idle(3);

        // Mid-operation reset with 3 queued entries
        for (int i = 0; i < 3; i++) step(1'b1, 32'h4000 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_en", {31'b0, update_en}, 32'd0);
        chk("mid_rst_ready", {31'b0, res_ready}, 32'd1);
        chk("mid_rst_stats", stat_branches | stat_mispredicts, 32'd0);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) == 0));
        idle(DEPTH + 3);

`ifdef BUQ_STATS_EN
        // Saturation
        @(negedge clk);
        dut.stat_br_q = 32'hFFFF_FFFE;
        m_br = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h8000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        idle(4);
        #1;
        chk("stat_saturate", stat_branches, 32'hFFFF_FFFF);
`endif

        #3;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

Buffers resolved conditional-branch outcomes from the execute stage and drains them, one per cycle, into the BHT update port (`update_en`, `update_pc`, `update_actual_taken`). It decouples branch resolution timing from BHT write timing: execute can resolve a branch in any cycle, and the fetch side can delay table writes with `update_hold`. The block sits directly upstream of the BHT update interface. It also optionally counts branches and mispredictions.

## Interface
- `DEPTH`, default 4: number of queue entries; must be a power of two, ≥2.
- `clk` input 1: core clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `res_valid` input 1: the execute stage presents a resolved branch.
- `res_ready` output 1: the queue can accept the record this cycle.
- `res_pc` input 32: PC of the resolved branch.
- `res_taken` input 1: actual outcome of the branch.
- `res_pred_taken` input 1: outcome that fetch predicted.
- `update_hold` input 1: when 1, no drain this cycle.
- `update_en` output 1: registered; one-cycle BHT write strobe.
- `update_pc` output 32: registered; PC for the BHT write.
- `update_actual_taken` output 1: registered; outcome for the BHT write.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `stat_branches` output 32: accepted-branch counter.
- `stat_mispredicts` output 32: misprediction counter.

## Operation
- Storage is a circular FIFO of {pc[31:0], taken} entries.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is an explicit occupancy register.
- Accept: `acc = res_valid & res_ready`.
  - On `acc`, write {res_pc, res_taken} at the write pointer, then advance the write pointer.
- Pop: `pop = (count != 0) & ~update_hold`.
  - On `pop`, load the head entry into the `update_pc` / `update_actual_taken` registers, set `update_en` = 1 for the next cycle, and advance the read pointer.
  - If there is no pop, `update_en` = 0 next cycle. `update_pc` and `update_actual_taken` hold their last values.
- Ready rule: `res_ready = (count != DEPTH) | pop`.
  - This is combinational from `count` and `update_hold`.
  - When the queue is full and a pop happens in the same cycle, a new record is still accepted.
- Occupancy update: `count_next = count + acc - pop`.
  - Simultaneous accept and pop leaves `count` unchanged.
  - Accept into an empty queue is never bypassed. The record is stored first and popped no earlier than the next edge.
- Ordering: strict FIFO. BHT writes occur in resolution order, including repeated writes to the same PC.
- Reset (`rst_n` = 0 at an edge) clears:
  - pointers and `count` to 0;
  - `update_en`, `update_pc`, `update_actual_taken` to 0;
  - stats to 0.
  
  Queued entries are discarded; reset mid-drain loses them. Entry storage itself is not reset.
- Reset values of the remaining outputs:
  - `res_ready` = 1 during and after reset (count = 0).
  - `count` = 0.

## Timing
- Latency from accept at edge N to `update_en` = 1 is two edges: the entry is popped at edge N+1, and the strobe is visible during the cycle after edge N+1. This assumes `update_hold` = 0 and the queue was empty.
- Throughput is one accept and one drain per cycle, sustained.
- `update_hold` sampled at edge E suppresses the pop at E. It does not cancel an `update_en` already asserted from edge E-1.
- `update_en` is never asserted on two consecutive cycles for the same entry.
- `res_pc` and `res_taken` are sampled only when `acc` = 1. Values when `res_valid` = 0 are don't-care.

## Configuration
- `BUQ_STATS_EN` defined:
  - On each `acc`, `stat_branches` increments.
  - On each `acc` with `res_taken != res_pred_taken`, `stat_mispredicts` increments.
  - Both counters saturate at 32'hFFFF_FFFF and never wrap.
  - Both clear on reset.
- `BUQ_STATS_EN` undefined:
  - Counter logic is not compiled.
  - `stat_branches` and `stat_mispredicts` are tied to 32'h0.
  - The port list is unchanged.

## Test plan
- Single branch: from reset, present pc=0x0000_0100, taken=1, pred=0 for one cycle. Required: `update_en` high for exactly one cycle, two edges later, with `update_pc` = 0x100 and `update_actual_taken` = 1. With stats on, `stat_branches` = 1 and `stat_mispredicts` = 1.
- Fill under hold: hold = 1, push pcs 0x10, 0x14, 0x18, 0x1C. Required: `count` = 4, `res_ready` = 0, and a fifth push is stalled. Release hold: four consecutive `update_en` pulses in order 0x10, 0x14, 0x18, 0x1C, and the fifth record is accepted in the first release cycle.
- Full plus simultaneous: with the queue full and hold dropping to 0, present a record in the same cycle. Required: `res_ready` = 1, the record is accepted, and `count` stays 4.
- Wrap-around: 3×DEPTH back-to-back records with hold = 0 and PCs incrementing by 4. Required: every PC emitted exactly once, in order, with no gaps after the pipeline fills.
- Mid-operation reset: with 3 entries queued, assert `rst_n` = 0 for one edge. Required: the next cycle has `count` = 0, `update_en` = 0, `res_ready` = 1, stats = 0, and no stale entry is ever emitted.
- Saturation (stats on): force `stat_branches` to 32'hFFFF_FFFE, then accept 3 branches. Required: the value ends at 32'hFFFF_FFFF.
